// File: rtl/scr1_ahb_mem_arb_if.sv
// Bus bundle for the two-master AHB-Lite arbiter: m0/m1 upstream ports, the shared slave port
// and owner/starvation debug state. Modport slave is the arbiter's view, master is the environment's.
interface scr1_ahb_mem_arb_if #(
   parameter int AHB_WIDTH = 32
);
   logic [1:0]           m0_htrans;
   logic [2:0]           m0_hsize;
   logic [3:0]           m0_hprot;
   logic [AHB_WIDTH-1:0] m0_haddr;
   logic                 m0_hready;
   logic [AHB_WIDTH-1:0] m0_hrdata;
   logic                 m0_hresp;

   logic [1:0]           m1_htrans;
   logic [2:0]           m1_hsize;
   logic [3:0]           m1_hprot;
   logic [AHB_WIDTH-1:0] m1_haddr;
   logic                 m1_hwrite;
   logic [AHB_WIDTH-1:0] m1_hwdata;
   logic                 m1_hready;
   logic [AHB_WIDTH-1:0] m1_hrdata;
   logic                 m1_hresp;

   logic [1:0]           s_htrans;
   logic [2:0]           s_hsize;
   logic [3:0]           s_hprot;
   logic [AHB_WIDTH-1:0] s_haddr;
   logic                 s_hwrite;
   logic [AHB_WIDTH-1:0] s_hwdata;
   logic                 s_hready;
   logic [AHB_WIDTH-1:0] s_hrdata;
   logic                 s_hresp;

   // Owner codes: 0 = none, 1 = m0, 2 = m1.
   logic [1:0]           dbg_dp_owner;
   logic [1:0]           dbg_addr_owner;
   logic [3:0]           dbg_starve_cnt;

   modport slave (
      input  m0_htrans, m0_hsize, m0_hprot, m0_haddr,
      output m0_hready, m0_hrdata, m0_hresp,
      input  m1_htrans, m1_hsize, m1_hprot, m1_haddr, m1_hwrite, m1_hwdata,
      output m1_hready, m1_hrdata, m1_hresp,
      output s_htrans, s_hsize, s_hprot, s_haddr, s_hwrite, s_hwdata,
      input  s_hready, s_hrdata, s_hresp,
      output dbg_dp_owner, dbg_addr_owner, dbg_starve_cnt
   );

   modport master (
      output m0_htrans, m0_hsize, m0_hprot, m0_haddr,
      input  m0_hready, m0_hrdata, m0_hresp,
      output m1_htrans, m1_hsize, m1_hprot, m1_haddr, m1_hwrite, m1_hwdata,
      input  m1_hready, m1_hrdata, m1_hresp,
      input  s_htrans, s_hsize, s_hprot, s_haddr, s_hwrite, s_hwdata,
      output s_hready, s_hrdata, s_hresp,
      input  dbg_dp_owner, dbg_addr_owner, dbg_starve_cnt
   );
endinterface

// File: rtl/scr1_ahb_mem_arb.sv
// Two-master AHB-Lite arbiter (imem m0 read-only, dmem m1) onto one slave, data-over-instruction
// priority with an imem starvation guard. Optional statistics counters: SCR1_AHB_ARB_STATS_EN.
//
// Handshake: an address phase is accepted when the slave drives s_hready = 1 at the clock edge;
// a master whose request loses arbitration sees its hready low and must hold its address.
module scr1_ahb_mem_arb #(
   parameter int AHB_WIDTH    = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   scr1_ahb_mem_arb_if.slave     bus
`ifdef SCR1_AHB_ARB_STATS_EN
   ,
   output logic [31:0]           gnt0_cnt,
   output logic [31:0]           gnt1_cnt,
   output logic [31:0]           stall_cnt
`endif
);
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [3:0] STARVE_MAX    = 4'(STARVE_LIMIT);

   owner_e     dp_owner;
   owner_e     addr_owner;
   owner_e     gnt_owner;
   logic [3:0] starve_cnt;
   logic       req0, req1, force0, gnt0, gnt1, stall0, stall1;

   always_comb begin
      req0   = (bus.m0_htrans == HTRANS_NONSEQ);
      req1   = (bus.m1_htrans == HTRANS_NONSEQ);
      force0 = req0 && (starve_cnt == STARVE_MAX);
      // addr_owner is non-NONE only while a granted address is waiting on the slave.
      if (addr_owner != OWN_NONE) begin
         gnt1 = (addr_owner == OWN_M1);
         gnt0 = (addr_owner == OWN_M0);
      end else begin
         gnt1 = req1 && !force0;
         gnt0 = req0 && !gnt1;
      end
      stall0    = req0 && !gnt0;
      stall1    = req1 && !gnt1;
      gnt_owner = gnt1 ? OWN_M1 : (gnt0 ? OWN_M0 : OWN_NONE);
   end

   always_comb begin
      bus.s_htrans = HTRANS_IDLE;
      bus.s_hsize  = 3'd0;
      bus.s_hprot  = 4'd0;
      bus.s_haddr  = {AHB_WIDTH{1'b0}};
      bus.s_hwrite = 1'b0;
      if (gnt1) begin
         bus.s_htrans = bus.m1_htrans;
         bus.s_hsize  = bus.m1_hsize;
         bus.s_hprot  = bus.m1_hprot;
         bus.s_haddr  = bus.m1_haddr;
         bus.s_hwrite = bus.m1_hwrite;
      end else if (gnt0) begin
         bus.s_htrans = bus.m0_htrans;
         bus.s_hsize  = bus.m0_hsize;
         bus.s_hprot  = bus.m0_hprot;
         bus.s_haddr  = bus.m0_haddr;
      end
      bus.s_hwdata = (dp_owner == OWN_M1) ? bus.m1_hwdata : {AHB_WIDTH{1'b0}};
   end

   always_comb begin
      bus.m0_hrdata = (dp_owner == OWN_M0) ? bus.s_hrdata : {AHB_WIDTH{1'b0}};
      bus.m0_hresp  = (dp_owner == OWN_M0) && bus.s_hresp;
      bus.m1_hrdata = (dp_owner == OWN_M1) ? bus.s_hrdata : {AHB_WIDTH{1'b0}};
      bus.m1_hresp  = (dp_owner == OWN_M1) && bus.s_hresp;
      if ((dp_owner == OWN_M0) || gnt0) bus.m0_hready = bus.s_hready;
      else                              bus.m0_hready = !stall0;
      if ((dp_owner == OWN_M1) || gnt1) bus.m1_hready = bus.s_hready;
      else                              bus.m1_hready = !stall1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dp_owner   <= OWN_NONE;
         addr_owner <= OWN_NONE;
         starve_cnt <= 4'd0;
      end else begin
         if (bus.s_hready) begin
            dp_owner   <= gnt_owner;
            addr_owner <= OWN_NONE;
         end else begin
            addr_owner <= gnt_owner;
         end
         if (!req0 || (gnt0 && bus.s_hready))
            starve_cnt <= 4'd0;
         else if (stall0 && bus.s_hready && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign bus.dbg_dp_owner   = dp_owner;
   assign bus.dbg_addr_owner = addr_owner;
   assign bus.dbg_starve_cnt = starve_cnt;

`ifdef SCR1_AHB_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0_cnt  <= 32'd0;
         gnt1_cnt  <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (gnt0 && bus.s_hready && (gnt0_cnt != 32'hFFFF_FFFF)) gnt0_cnt <= gnt0_cnt + 32'd1;
         if (gnt1 && bus.s_hready && (gnt1_cnt != 32'hFFFF_FFFF)) gnt1_cnt <= gnt1_cnt + 32'd1;
         if ((stall0 || stall1) && (stall_cnt != 32'hFFFF_FFFF))  stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// Directed bench for scr1_ahb_mem_arb: single-cycle arbitration vectors from reset, then
// multi-cycle sequences for back-to-back issue, starvation, wait states, ERROR and reset.
module tb_scr1_ahb_mem_arb;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   scr1_ahb_mem_arb_if #(.AHB_WIDTH(32)) bus ();

`ifdef SCR1_AHB_ARB_STATS_EN
   logic [31:0] gnt0_cnt, gnt1_cnt, stall_cnt;
   scr1_ahb_mem_arb #(.AHB_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .stall_cnt(stall_cnt));
`else
   scr1_ahb_mem_arb #(.AHB_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  m0_t;
      logic [31:0] m0_a;
      logic [1:0]  m1_t;
      logic [31:0] m1_a;
      logic        m1_w;
      logic        s_rdy;
      logic [1:0]  e_htrans;
      logic [31:0] e_haddr;
      logic        e_hwrite;
      logic [2:0]  e_hsize;
      logic        e_m0_rdy;
      logic        e_m1_rdy;
      logic [1:0]  e_dp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic [1:0] t1,
                        input logic [31:0] a1, input logic w1, input logic rdy);
      bus.m0_htrans = t0;
      bus.m0_haddr  = a0;
      bus.m1_htrans = t1;
      bus.m1_haddr  = a1;
      bus.m1_hwrite = w1;
      bus.s_hready  = rdy;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(IDLE, 32'h0, IDLE, 32'h0, 1'b0, 1'b1);
      bus.m0_hsize  = 3'd2;
      bus.m0_hprot  = 4'hA;
      bus.m1_hsize  = 3'd1;
      bus.m1_hprot  = 4'h3;
      bus.m1_hwdata = 32'h0;
      bus.s_hrdata  = 32'h0;
      bus.s_hresp   = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;

      //         m0_t    m0_a        m1_t    m1_a        w     rdy   htrans  haddr       wr    sz    m0r   m1r   dp
      vecs[0] = '{IDLE,   32'h0,      IDLE,   32'h0,      1'b0, 1'b1, IDLE,   32'h0,      1'b0, 3'd0, 1'b1, 1'b1, 2'd0};
      vecs[1] = '{NONSEQ, 32'h10,     IDLE,   32'h0,      1'b0, 1'b1, NONSEQ, 32'h10,     1'b0, 3'd2, 1'b1, 1'b1, 2'd1};
      vecs[2] = '{IDLE,   32'h0,      NONSEQ, 32'h20,     1'b1, 1'b1, NONSEQ, 32'h20,     1'b1, 3'd1, 1'b1, 1'b1, 2'd2};
      vecs[3] = '{NONSEQ, 32'h14,     NONSEQ, 32'h24,     1'b0, 1'b1, NONSEQ, 32'h24,     1'b0, 3'd1, 1'b0, 1'b1, 2'd2};
      vecs[4] = '{SEQ,    32'h18,     BUSY,   32'h28,     1'b1, 1'b1, IDLE,   32'h0,      1'b0, 3'd0, 1'b1, 1'b1, 2'd0};
      vecs[5] = '{NONSEQ, 32'h30,     IDLE,   32'h0,      1'b0, 1'b0, NONSEQ, 32'h30,     1'b0, 3'd2, 1'b0, 1'b1, 2'd0};
      vecs[6] = '{NONSEQ, 32'h34,     NONSEQ, 32'h40,     1'b1, 1'b0, NONSEQ, 32'h40,     1'b1, 3'd1, 1'b0, 1'b0, 2'd0};
      vecs[7] = '{BUSY,   32'h38,     NONSEQ, 32'h44,     1'b1, 1'b1, NONSEQ, 32'h44,     1'b1, 3'd1, 1'b1, 1'b1, 2'd2};
      vecs[8] = '{NONSEQ, 32'h50,     SEQ,    32'h54,     1'b1, 1'b1, NONSEQ, 32'h50,     1'b0, 3'd2, 1'b1, 1'b1, 2'd1};

      do_reset();
      settle();
      chk("rst_dp_owner", 32'(bus.dbg_dp_owner), 32'd0);
      chk("rst_starve", 32'(bus.dbg_starve_cnt), 32'd0);
      chk("rst_s_htrans", 32'(bus.s_htrans), 32'(IDLE));
      chk("rst_m0_hready", 32'(bus.m0_hready), 32'd1);
      chk("rst_m1_hready", 32'(bus.m1_hready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         do_reset();
         drive(vecs[i].m0_t, vecs[i].m0_a, vecs[i].m1_t, vecs[i].m1_a, vecs[i].m1_w, vecs[i].s_rdy);
         settle();
         chk($sformatf("v%0d_htrans", i), 32'(bus.s_htrans), 32'(vecs[i].e_htrans));
         chk($sformatf("v%0d_haddr", i), bus.s_haddr, vecs[i].e_haddr);
         chk($sformatf("v%0d_hwrite", i), 32'(bus.s_hwrite), 32'(vecs[i].e_hwrite));
         chk($sformatf("v%0d_hsize", i), 32'(bus.s_hsize), 32'(vecs[i].e_hsize));
         chk($sformatf("v%0d_m0_hready", i), 32'(bus.m0_hready), 32'(vecs[i].e_m0_rdy));
         chk($sformatf("v%0d_m1_hready", i), 32'(bus.m1_hready), 32'(vecs[i].e_m1_rdy));
         tick();
         chk($sformatf("v%0d_dp_owner", i), 32'(bus.dbg_dp_owner), 32'(vecs[i].e_dp));
      end

      // Single m0 read, data routed back in the next cycle.
      do_reset();
      drive(NONSEQ, 32'h100, IDLE, 32'h0, 1'b0, 1'b1);
      settle();
      chk("rd_haddr", bus.s_haddr, 32'h100);
      chk("rd_hprot", 32'(bus.s_hprot), 32'hA);
      chk("rd_m1_hready", 32'(bus.m1_hready), 32'd1);
      tick();
      drive(IDLE, 32'h0, IDLE, 32'h0, 1'b0, 1'b1);
      bus.s_hrdata = 32'hCAFE0001;
      settle();
      chk("rd_dp_owner", 32'(bus.dbg_dp_owner), 32'd1);
      chk("rd_m0_hrdata", bus.m0_hrdata, 32'hCAFE0001);
      chk("rd_m1_hrdata", bus.m1_hrdata, 32'h0);
      chk("rd_m0_hready", 32'(bus.m0_hready), 32'd1);

      // Simultaneous request: m1 write wins, m0 issued next cycle alongside write data.
      do_reset();
      drive(NONSEQ, 32'h104, NONSEQ, 32'h200, 1'b1, 1'b1);
      settle();
      chk("sim_haddr", bus.s_haddr, 32'h200);
      chk("sim_hwrite", 32'(bus.s_hwrite), 32'd1);
      chk("sim_m0_hready", 32'(bus.m0_hready), 32'd0);
      tick();
      drive(NONSEQ, 32'h104, IDLE, 32'h0, 1'b0, 1'b1);
      bus.m1_hwdata = 32'hDEADBEEF;
      settle();
      chk("sim_hwdata", bus.s_hwdata, 32'hDEADBEEF);
      chk("sim_haddr2", bus.s_haddr, 32'h104);
      chk("sim_hwrite2", 32'(bus.s_hwrite), 32'd0);
      chk("sim_m0_hready2", 32'(bus.m0_hready), 32'd1);
      tick();
      drive(IDLE, 32'h0, IDLE, 32'h0, 1'b0, 1'b1);
      settle();
      chk("sim_dp_m0", 32'(bus.dbg_dp_owner), 32'd1);
      chk("sim_hwdata_off", bus.s_hwdata, 32'h0);

      // Starvation: m0 force-granted on the 5th contested cycle.
      do_reset();
      drive(NONSEQ, 32'h300, NONSEQ, 32'h400, 1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         settle();
         chk($sformatf("stv%0d_cnt", k), 32'(bus.dbg_starve_cnt), 32'(k - 1));
         chk($sformatf("stv%0d_haddr", k), bus.s_haddr, (k == 5) ? 32'h300 : 32'h400);
         chk($sformatf("stv%0d_m0_hready", k), 32'(bus.m0_hready), (k == 5) ? 32'd1 : 32'd0);
         tick();
      end
      settle();
      chk("stv_cnt_clear", 32'(bus.dbg_starve_cnt), 32'd0);
      chk("stv_m1_again", bus.s_haddr, 32'h400);

      // Three wait states in m1 data phase; m0 grant frozen while m1 re-requests.
      do_reset();
      drive(IDLE, 32'h0, NONSEQ, 32'h500, 1'b0, 1'b1);
      tick();
      for (int w = 0; w < 3; w++) begin
         if (w == 0) drive(NONSEQ, 32'h600, IDLE, 32'h0, 1'b0, 1'b0);
         else        drive(NONSEQ, 32'h600, NONSEQ, 32'h700, 1'b0, 1'b0);
         settle();
         chk($sformatf("ws%0d_haddr", w), bus.s_haddr, 32'h600);
         chk($sformatf("ws%0d_htrans", w), 32'(bus.s_htrans), 32'(NONSEQ));
         chk($sformatf("ws%0d_m1_hready", w), 32'(bus.m1_hready), 32'd0);
         chk($sformatf("ws%0d_m0_hready", w), 32'(bus.m0_hready), 32'd0);
         tick();
         chk($sformatf("ws%0d_addr_owner", w), 32'(bus.dbg_addr_owner), 32'd1);
      end
      drive(NONSEQ, 32'h600, NONSEQ, 32'h700, 1'b0, 1'b1);
      bus.s_hrdata = 32'h11223344;
      settle();
      chk("ws_end_haddr", bus.s_haddr, 32'h600);
      chk("ws_end_m1_hrdata", bus.m1_hrdata, 32'h11223344);
      chk("ws_end_m0_hrdata", bus.m0_hrdata, 32'h0);
      chk("ws_end_m0_hready", 32'(bus.m0_hready), 32'd1);
      chk("ws_end_m1_hready", 32'(bus.m1_hready), 32'd1);
      tick();
      drive(IDLE, 32'h0, NONSEQ, 32'h700, 1'b0, 1'b1);
      settle();
      chk("ws_dp_m0", 32'(bus.dbg_dp_owner), 32'd1);
      chk("ws_m1_issued", bus.s_haddr, 32'h700);

      // Two-cycle ERROR on an m0 read.
      do_reset();
      drive(NONSEQ, 32'h800, IDLE, 32'h0, 1'b0, 1'b1);
      tick();
      drive(IDLE, 32'h0, IDLE, 32'h0, 1'b0, 1'b0);
      bus.s_hresp = 1'b1;
      settle();
      chk("err1_m0_hresp", 32'(bus.m0_hresp), 32'd1);
      chk("err1_m0_hready", 32'(bus.m0_hready), 32'd0);
      chk("err1_m1_hresp", 32'(bus.m1_hresp), 32'd0);
      tick();
      bus.s_hready = 1'b1;
      settle();
      chk("err2_m0_hresp", 32'(bus.m0_hresp), 32'd1);
      chk("err2_m0_hready", 32'(bus.m0_hready), 32'd1);
      chk("err2_m1_hresp", 32'(bus.m1_hresp), 32'd0);
      tick();
      bus.s_hresp = 1'b0;
      settle();
      chk("err_dp_none", 32'(bus.dbg_dp_owner), 32'd0);

      // Reset during an m1 wait state abandons the data phase.
      do_reset();
      drive(IDLE, 32'h0, NONSEQ, 32'h900, 1'b0, 1'b1);
      tick();
      drive(IDLE, 32'h0, IDLE, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.s_hresp = 1'b1;
      settle();
      chk("mrst_dp_owner", 32'(bus.dbg_dp_owner), 32'd0);
      chk("mrst_s_htrans", 32'(bus.s_htrans), 32'(IDLE));
      chk("mrst_m0_hready", 32'(bus.m0_hready), 32'd1);
      chk("mrst_m1_hready", 32'(bus.m1_hready), 32'd1);
      chk("mrst_m1_hresp", 32'(bus.m1_hresp), 32'd0);
`ifdef SCR1_AHB_ARB_STATS_EN
      chk("mrst_gnt0_cnt", gnt0_cnt, 32'd0);
      chk("mrst_gnt1_cnt", gnt1_cnt, 32'd0);
      chk("mrst_stall_cnt", stall_cnt, 32'd0);
`endif
      bus.s_hresp = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/scr1_ahb_mem_arb.md
Name: scr1_ahb_mem_arb

Overview:
- Two-master AHB-Lite arbiter. It merges the core's instruction port (m0, read-only) and data port (m1) onto a single AHB-Lite slave port, such as a shared TCM or unified memory model.
- Tracks data-phase ownership so responses are routed back correctly.
- Stalls the losing master by holding its hready low during its address phase.
- Fixed data-over-instruction priority, with a starvation guard for imem.

Parameters:
- AHB_WIDTH, 32, address/data width.
- STARVE_LIMIT, 4, consecutive cycles m0 may be denied before it is force-granted (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m0_htrans  in  2  imem transfer type.
- m0_hsize  in  3  imem size.
- m0_hprot  in  4  imem protection.
- m0_haddr  in  AHB_WIDTH  imem address.
- m0_hready  out  1  imem ready.
- m0_hrdata  out  AHB_WIDTH  imem read data.
- m0_hresp  out  1  imem response.
- m1_htrans  in  2  dmem transfer type.
- m1_hsize  in  3  dmem size.
- m1_hprot  in  4  dmem protection.
- m1_haddr  in  AHB_WIDTH  dmem address.
- m1_hwrite  in  1  dmem write.
- m1_hwdata  in  AHB_WIDTH  dmem write data.
- m1_hready  out  1  dmem ready.
- m1_hrdata  out  AHB_WIDTH  dmem read data.
- m1_hresp  out  1  dmem response.
- s_htrans  out  2  slave transfer type.
- s_hsize  out  3  slave size.
- s_hprot  out  4  slave protection.
- s_haddr  out  AHB_WIDTH  slave address.
- s_hwrite  out  1  slave write.
- s_hwdata  out  AHB_WIDTH  slave write data.
- s_hready  in  1  slave ready.
- s_hrdata  in  AHB_WIDTH  slave read data.
- s_hresp  in  1  slave response.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Requests:
  - req0 = (m0_htrans == NONSEQ).
  - req1 = (m1_htrans == NONSEQ).
  - SEQ/BUSY never occur (single transfers only). They are treated as IDLE.
- Grant (combinational, address phase):
  - gnt1 = req1 & ~force0.
  - gnt0 = req0 & ~gnt1.
  - force0 = req0 & (starve_cnt == STARVE_LIMIT).
- Slave address mux:
  - s_htrans/hsize/hprot/haddr come from the granted master.
  - s_hwrite = gnt1 & m1_hwrite.
  - No grant: s_htrans = IDLE, all other address outputs 0.
- Data-phase owner register dp_owner (states NONE, M0, M1):
  - Updates only when s_hready = 1.
  - Next value = M1 if gnt1, M0 if gnt0, else NONE.
  - Holds while s_hready = 0.
- Write data: s_hwdata = m1_hwdata when dp_owner == M1, else 0.
- Response routing:
  - mX_hrdata = s_hrdata, mX_hresp = s_hresp when dp_owner == MX; otherwise hrdata 0, hresp 0.
  - Two-cycle ERROR passes through unchanged. dp_owner does not change while s_hready = 0.
- mX_hready:
  - s_hready if dp_owner == MX or gntX.
  - 0 if reqX & ~gntX (stall: the master holds its address).
  - 1 otherwise (idle OKAY).
- Starvation counter starve_cnt (4 bits):
  - Increments when req0 & ~gnt0 & s_hready.
  - Clears when gnt0 & s_hready, or when ~req0.
  - Saturates at STARVE_LIMIT.
- Simultaneous events:
  - Grant change is accepted only with s_hready = 1.
  - While s_hready = 0, the grant is frozen to the master whose address is pending (registered addr_owner). This keeps s_* stable per AHB rules.
- Reset values:
  - dp_owner = NONE, addr_owner = NONE, starve_cnt = 0.
  - Therefore after reset: s_htrans = IDLE, m0_hready = m1_hready = 1, hresp = 0.
  - A reset asserted mid-transfer abandons the data phase. No response is forwarded after reset.
- Latency: zero added cycles. The arbiter is purely pass-through apart from the owner/starve registers.

Optional Feature:
- Macro: SCR1_AHB_ARB_STATS_EN.
- When defined, adds outputs:
  - gnt0_cnt  out 32: accepted m0 transfers.
  - gnt1_cnt  out 32: accepted m1 transfers.
  - stall_cnt  out 32: cycles any master was stalled by arbitration.
- Counter rules: all saturating, reset to 0 by rst, increment on (gntX & s_hready) and (stall) respectively.
- When undefined, the ports and counters are absent. Function is otherwise identical.

Test Plan:
- Single m0 read of 0x100, s_hready = 1 → s_haddr = 0x100, dp_owner = M0 next cycle, m0_hrdata = s_hrdata, m1_hready = 1.
- m0 and m1 NONSEQ in the same cycle (m1 write 0x200, data 0xDEADBEEF) → m1 granted, m0_hready = 0; next cycle s_hwdata = 0xDEADBEEF, m0 address 0x104 issued.
- m1 requests continuously, m0 requesting, STARVE_LIMIT = 4 → m0 force-granted on the 5th cycle, starve_cnt returns to 0.
- Slave inserts 3 wait states during m1 data phase while m0 requests → s_haddr/s_htrans stable, m1_hready low 3 cycles, m0_hready low throughout.
- Slave ERROR (two-cycle: hresp = 1, hready = 0 then hresp = 1, hready = 1) on m0 read → m0_hresp high both cycles, m1_hresp = 0.
- rst pulsed during m1 wait state → next cycle dp_owner = NONE, s_htrans = IDLE, both hready = 1. With SCR1_AHB_ARB_STATS_EN, all counters = 0.
